gpio_pattern_bank: RTL and testbench
====================================

Name: gpio_pattern_bank

Overview:
- Parametrised multi-channel GPIO waveform generator; next generation of the single-channel fixed-period blinker.
- Each channel runs its own period counter in one of four modes: OFF, TOGGLE, PWM or ONESHOT.
- Channels are reconfigured at run time through a single-cycle write port.
- Drives board GPIO pins directly and sits alongside board-level control logic.

Parameters:
- N_CH, 4, number of independent channels (1..16).
- CNT_W, 27, width of the counter, period and duty fields.
- DEF_PERIOD, 50000000, period loaded into every channel at reset.
- CH_W, $clog2(N_CH) (minimum 1), width of the channel select field.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_cfg_we  input  1  config write strobe, one cycle per write.
- i_cfg_ch  input  CH_W  target channel for the write.
- i_cfg_mode  input  2  mode select: 0 OFF, 1 TOGGLE, 2 PWM, 3 ONESHOT.
- i_cfg_period  input  CNT_W  period value (P).
- i_cfg_duty  input  CNT_W  duty value (D).
- i_trig  input  N_CH  per-channel one-shot trigger, rising-edge sensitive.
- o_gpio  output  N_CH  channel outputs, each driven directly from a flop.
- o_busy  output  N_CH  high while a one-shot pulse is active.
- o_wrap  output  N_CH  high in the cycle where cnt==P (TOGGLE and PWM only).

Behaviour:
- Reset (async, i_rst_n low):
  - every channel: mode=TOGGLE, P=DEF_PERIOD, D=0, cnt=0;
  - o_gpio=0, o_busy=0, trigger edge-history flops=0;
  - o_wrap is therefore 0 during reset.
- Per-channel counter arithmetic:
  - cnt runs 0..P inclusive, i.e. P+1 cycles per period;
  - at cnt==P, the next value is 0;
  - unsigned arithmetic throughout, no overflow possible since cnt<=P.
- OFF: cnt held at 0; o_gpio=0; o_wrap=0; o_busy=0.
- TOGGLE:
  - cnt free-runs;
  - on the edge where cnt==P, o_gpio inverts;
  - each half-period is P+1 cycles; P=0 gives a toggle every cycle.
- PWM:
  - o_gpio is valid in the same cycle as cnt and equals (cnt<D);
  - implement by registering the compare of the next count, so the output stays glitch-free;
  - D=0 gives constant 0; D>P gives constant 1;
  - any change of D takes effect only through a config write.
- ONESHOT:
  - Idle state: o_gpio=0, o_busy=0, cnt=0.
  - A rising edge on i_trig[c] (current=1, previous sample=0) seen at a clock edge starts the pulse: next cycle o_gpio=1, o_busy=1, cnt=0.
  - While busy, cnt counts up; on the edge where cnt==P, o_gpio=0, o_busy=0, cnt=0.
  - Pulse width is exactly P+1 cycles.
  - Rising edges while busy, including one on the terminating edge, are ignored; a new rising edge is required to restart.
  - D is unused in ONESHOT.
- Config write (i_cfg_we=1 at a clock edge):
  - channel i_cfg_ch latches mode/P/D;
  - that channel's cnt, o_gpio and o_busy are cleared to 0 at the same edge;
  - other channels are unaffected;
  - i_cfg_ch>=N_CH: write ignored.
- Simultaneous events on the same channel:
  - a config write has priority over wrap, toggle and trigger;
  - the trigger is dropped;
  - the trigger edge-history flop still updates.
- Reset asserted mid-operation returns all state to reset values immediately; counting restarts from 0 after release.
- i_trig is assumed synchronous to i_clk; any synchronisers are external to this block.
- Expected implementation size: per-channel logic in a generate loop, about 200 lines.

Test Plan:
1. Reset, then P=3 written to ch0 in TOGGLE -> o_gpio[0] toggles every 4 cycles; o_wrap[0] pulses 1 cycle before each toggle.
2. ch1 PWM, P=9, D=3 -> o_gpio[1] high 3 cycles, low 7, repeating; D=0 gives constant 0; D=12 gives constant 1; o_wrap[1] once per 10 cycles.
3. ch2 ONESHOT, P=4, single-cycle i_trig[2] pulse -> o_gpio[2] and o_busy[2] high exactly 5 cycles, starting the cycle after the trigger edge; a second trigger during the pulse has no effect; i_trig held high after the pulse causes no retrigger.
4. Config write to ch0 in the same cycle cnt==P -> no toggle; cnt=0, o_gpio[0]=0 next cycle; new P is in effect.
5. Write with i_cfg_ch=N_CH (N_CH power of 2 needs CH_W+1, so use N_CH=3 with ch=3) -> all channels unchanged.
6. Async reset asserted mid-PWM and mid-oneshot -> o_gpio=0 and o_busy=0 immediately; after release every channel toggles with period DEF_PERIOD (use a small DEF_PERIOD override, e.g. 5 -> 6-cycle half-periods).

Source files
------------

// File: rtl/gpio_pattern_bank.sv
// Multi-channel GPIO waveform generator. Each channel has its own period counter
// and runs in OFF, TOGGLE, PWM or ONESHOT mode, reconfigured through a one-cycle write port.
module gpio_pattern_bank #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 27,
  parameter int DEF_PERIOD = 50000000,
  parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_we,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [1:0]       i_cfg_mode,
  input  logic [CNT_W-1:0] i_cfg_period,
  input  logic [CNT_W-1:0] i_cfg_duty,
  input  logic [N_CH-1:0]  i_trig,
  output logic [N_CH-1:0]  o_gpio,
  output logic [N_CH-1:0]  o_busy,
  output logic [N_CH-1:0]  o_wrap
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_TOGGLE  = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);

  // Counter runs 0..P inclusive, so a period is P+1 cycles.
  function automatic logic [CNT_W-1:0] f_cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic [CNT_W-1:0] per);
    return (cnt == per) ? '0 : cnt + CNT_W'(1);
  endfunction

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    mode_e            r_mode;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gpio;
    logic             r_busy;
    logic             r_trig_d;
    logic             w_sel;
    logic             w_rise;
    logic             w_end;
    logic [CNT_W-1:0] w_cnt_wrap;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_gpio_nxt;
    logic             w_busy_nxt;

    assign w_sel      = i_cfg_we && (i_cfg_ch == CH_W'(c));
    assign w_rise     = i_trig[c] & ~r_trig_d;
    assign w_end      = (r_cnt == r_per);
    assign w_cnt_wrap = f_cnt_next(r_cnt, r_per);

    always_comb begin
      w_cnt_nxt  = '0;
      w_gpio_nxt = 1'b0;
      w_busy_nxt = 1'b0;
      case (r_mode)
        MODE_OFF: begin
        end
        MODE_TOGGLE: begin
          w_cnt_nxt  = w_cnt_wrap;
          w_gpio_nxt = r_gpio ^ w_end;
        end
        // Registering the compare of the next count keeps gpio aligned with cnt.
        MODE_PWM: begin
          w_cnt_nxt  = w_cnt_wrap;
          w_gpio_nxt = (w_cnt_wrap < r_duty);
        end
        MODE_ONESHOT: begin
          if (r_busy) begin
            if (!w_end) begin
              w_cnt_nxt  = w_cnt_wrap;
              w_gpio_nxt = 1'b1;
              w_busy_nxt = 1'b1;
            end
          end else if (w_rise) begin
            w_gpio_nxt = 1'b1;
            w_busy_nxt = 1'b1;
          end
        end
      endcase
    end

    // A config write wins over wrap, toggle and trigger; edge history still tracks i_trig.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_mode   <= MODE_TOGGLE;
        r_per    <= DEF_P;
        r_duty   <= '0;
        r_cnt    <= '0;
        r_gpio   <= 1'b0;
        r_busy   <= 1'b0;
        r_trig_d <= 1'b0;
      end else begin
        r_trig_d <= i_trig[c];
        if (w_sel) begin
          r_mode <= mode_e'(i_cfg_mode);
          r_per  <= i_cfg_period;
          r_duty <= i_cfg_duty;
          r_cnt  <= '0;
          r_gpio <= 1'b0;
          r_busy <= 1'b0;
        end else begin
          r_cnt  <= w_cnt_nxt;
          r_gpio <= w_gpio_nxt;
          r_busy <= w_busy_nxt;
        end
      end
    end

    assign o_gpio[c] = r_gpio;
    assign o_busy[c] = r_busy;
    assign o_wrap[c] = w_end && ((r_mode == MODE_TOGGLE) || (r_mode == MODE_PWM));
  end

endmodule

// File: tb/tb_gpio_pattern_bank.sv
// Directed bench for gpio_pattern_bank: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_gpio_pattern_bank;
  localparam int N    = 3;
  localparam int CW   = 8;
  localparam int DEFP = 5;
  localparam int CHW  = 2;

  localparam logic [1:0] M_OFF = 2'd0, M_TOG = 2'd1, M_PWM = 2'd2, M_ONE = 2'd3;
  localparam int S_GPIO = 0, S_BUSY = 1, S_WRAP = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_cfg_we;
  logic [CHW-1:0] i_cfg_ch;
  logic [1:0]    i_cfg_mode;
  logic [CW-1:0] i_cfg_period;
  logic [CW-1:0] i_cfg_duty;
  logic [N-1:0]  i_trig;
  logic [N-1:0]  o_gpio;
  logic [N-1:0]  o_busy;
  logic [N-1:0]  o_wrap;

  gpio_pattern_bank #(.N_CH(N), .CNT_W(CW), .DEF_PERIOD(DEFP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch),
    .i_cfg_mode(i_cfg_mode), .i_cfg_period(i_cfg_period), .i_cfg_duty(i_cfg_duty),
    .i_trig(i_trig), .o_gpio(o_gpio), .o_busy(o_busy), .o_wrap(o_wrap)
  );

  initial forever #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int          cy;
    string       nm;
    int          sel;
    logic [N-1:0] m;
    logic [N-1:0] e;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  exp_t t;
  logic [N-1:0] act;

  function automatic void push_m(int cy, string nm, int sel, logic [N-1:0] m, logic [N-1:0] e);
    exp_t x;
    x.cy = cy; x.nm = nm; x.sel = sel; x.m = m; x.e = e;
    q.push_back(x);
  endfunction

  function automatic void push(int cy, string nm, int sel, int ch, bit e);
    logic [N-1:0] m;
    m = N'(1) << ch;
    push_m(cy, nm, sel, m, e ? m : '0);
  endfunction

  always @(negedge i_clk) begin
    while (q.size() > 0 && q[0].cy <= cyc) begin
      t = q.pop_front();
      act = (t.sel == S_GPIO) ? o_gpio : (t.sel == S_BUSY) ? o_busy : o_wrap;
      checks++;
      if (t.cy != cyc || (act & t.m) != (t.e & t.m)) begin
        errors++;
        $display("FAIL %s cyc=%0d due=%0d got=%b want=%b mask=%b",
                 t.nm, cyc, t.cy, act & t.m, t.e & t.m, t.m);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic cfg(input int ch, input logic [1:0] mode, input int per, input int duty);
    i_cfg_we     = 1'b1;
    i_cfg_ch     = CHW'(ch);
    i_cfg_mode   = mode;
    i_cfg_period = CW'(per);
    i_cfg_duty   = CW'(duty);
    step(1);
    i_cfg_we     = 1'b0;
  endtask

  bit trig_tab [19] = '{1,0,1,1,1,1,1,1,0,0,1,0,0,0,0,1,1,1,0};
  bit busy_tab [19] = '{0,1,1,1,1,1,0,0,0,0,0,1,1,1,1,1,0,0,0};

  int w, w3, s, v, x, a, r, cy;

  initial begin
    i_rst_n = 1'b0; i_cfg_we = 1'b0; i_cfg_ch = '0; i_cfg_mode = '0;
    i_cfg_period = '0; i_cfg_duty = '0; i_trig = '0;
    step(1);
    for (int k = 1; k <= 2; k++) begin
      push_m(k, "rst_gpio", S_GPIO, '1, '0);
      push_m(k, "rst_busy", S_BUSY, '1, '0);
      push_m(k, "rst_wrap", S_WRAP, '1, '0);
    end
    step(2);
    i_rst_n = 1'b1;

    // ch0 TOGGLE P=3
    cfg(0, M_TOG, 3, 0);
    w = cyc;
    for (int j = 0; j < 16; j++) begin
      push(w + j, "t1_gpio", S_GPIO, 0, ((j / 4) % 2) == 1);
      push(w + j, "t1_wrap", S_WRAP, 0, (j % 4) == 3);
    end
    step(16);

    // ch1 PWM P=9 with D=3, D=0, D=12
    cfg(1, M_PWM, 9, 3);
    w = cyc;
    for (int j = 0; j < 25; j++) begin
      push(w + j, "t2_pwm3", S_GPIO, 1, j > 0 && (j % 10) < 3);
      push(w + j, "t2_wrap", S_WRAP, 1, (j % 10) == 9);
    end
    step(25);
    cfg(1, M_PWM, 9, 0);
    w = cyc;
    for (int j = 0; j < 12; j++) begin
      push(w + j, "t2_pwm0", S_GPIO, 1, 1'b0);
      push(w + j, "t2_wrap0", S_WRAP, 1, (j % 10) == 9);
    end
    step(12);
    cfg(1, M_PWM, 9, 12);
    w3 = cyc;
    for (int j = 0; j < 12; j++) begin
      push(w3 + j, "t2_pwm12", S_GPIO, 1, j > 0);
      push(w3 + j, "t2_wrap12", S_WRAP, 1, (j % 10) == 9);
    end
    step(12);

    // ch2 ONESHOT P=4: trigger, retrigger while busy, held high, edge on terminating cycle
    cfg(2, M_ONE, 4, 7);
    step(2);
    s = cyc;
    for (int k = 0; k < 19; k++) begin
      i_trig[2] = trig_tab[k];
      push(s + k, "t3_gpio", S_GPIO, 2, busy_tab[k]);
      push(s + k, "t3_busy", S_BUSY, 2, busy_tab[k]);
      push(s + k, "t3_wrap", S_WRAP, 2, 1'b0);
      step(1);
    end

    // ch0 write landing on cnt==P
    cfg(0, M_TOG, 3, 0);
    w = cyc;
    for (int j = 0; j < 4; j++) begin
      push(w + j, "t4_pre_gpio", S_GPIO, 0, 1'b0);
      push(w + j, "t4_pre_wrap", S_WRAP, 0, j == 3);
    end
    step(3);
    cfg(0, M_TOG, 1, 0);
    v = cyc;
    for (int j = 0; j < 8; j++) begin
      push(v + j, "t4_gpio", S_GPIO, 0, ((j / 2) % 2) == 1);
      push(v + j, "t4_wrap", S_WRAP, 0, (j % 2) == 1);
    end
    step(8);

    // write to out-of-range channel 3
    cfg(3, M_OFF, 0, 0);
    x = cyc;
    for (int j = 0; j < 8; j++) begin
      cy = x + j;
      push(cy, "t5_ch0_gpio", S_GPIO, 0, (((cy - v) / 2) % 2) == 1);
      push(cy, "t5_ch0_wrap", S_WRAP, 0, ((cy - v) % 2) == 1);
      push(cy, "t5_ch1_gpio", S_GPIO, 1, 1'b1);
      push(cy, "t5_ch1_wrap", S_WRAP, 1, ((cy - w3) % 10) == 9);
      push(cy, "t5_ch2_gpio", S_GPIO, 2, 1'b0);
      push(cy, "t5_ch2_busy", S_BUSY, 2, 1'b0);
    end
    step(8);

    // async reset mid-PWM and mid-oneshot
    cfg(1, M_PWM, 9, 5);
    a = cyc;
    i_trig[2] = 1'b1;
    step(1);
    i_trig[2] = 1'b0;
    push(a + 1, "t6_pre_busy1", S_BUSY, 2, 1'b1);
    step(1);
    push(a + 2, "t6_pre_pwm", S_GPIO, 1, 1'b1);
    push(a + 2, "t6_pre_gpio2", S_GPIO, 2, 1'b1);
    push(a + 2, "t6_pre_busy2", S_BUSY, 2, 1'b1);
    step(1);
    #1;
    i_rst_n = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      push_m(a + k, "t6_rst_gpio", S_GPIO, '1, '0);
      push_m(a + k, "t6_rst_busy", S_BUSY, '1, '0);
      push_m(a + k, "t6_rst_wrap", S_WRAP, '1, '0);
    end
    step(2);
    i_rst_n = 1'b1;
    r = cyc;
    for (int j = 0; j < 18; j++) begin
      push_m(r + j, "t6_gpio", S_GPIO, '1, (((j / 6) % 2) == 1) ? '1 : '0);
      push_m(r + j, "t6_wrap", S_WRAP, '1, ((j % 6) == 5) ? '1 : '0);
      push_m(r + j, "t6_busy", S_BUSY, '1, '0);
    end
    step(18);

    step(2);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
